// File: rtl/seg7_scan_driver.sv
// Six-digit multiplexed 7-segment scan driver, frame-coherent BCD snapshot; SEG7_LZB_EN blanks a leading zero.
// Latency: one cycle, because every output is registered from the pre-edge cnt/idx/snap.
// Backpressure: none; free-running scan, and blank gates only the anodes and dp.
module seg7_scan_driver #(
  parameter int         SCAN_DIV = 50000,
  parameter int         GUARD    = 16,
  parameter logic [5:0] DP_MASK  = 6'b010100
) (
  input  logic       clk,
  input  logic       res,
  input  logic [3:0] DIG0,
  input  logic [3:0] DIG1,
  input  logic [3:0] DIG2,
  input  logic [3:0] DIG3,
  input  logic [3:0] DIG4,
  input  logic [3:0] DIG5,
  input  logic       blank,
  output logic [5:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n
);

  localparam int            CW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
  localparam logic [7:0]    DP_MASK8  = {2'b00, DP_MASK};

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [3:0]    snap [6];

  logic          slot_end;
  logic          frame_end;
  logic          lit;
  logic          lzb;
  logic [3:0]    cur_dig;
  logic [5:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  function automatic logic [6:0] bcd_decode(input logic [3:0] d);
    case (d)
      4'd0:    bcd_decode = 7'h40;
      4'd1:    bcd_decode = 7'h79;
      4'd2:    bcd_decode = 7'h24;
      4'd3:    bcd_decode = 7'h30;
      4'd4:    bcd_decode = 7'h19;
      4'd5:    bcd_decode = 7'h12;
      4'd6:    bcd_decode = 7'h02;
      4'd7:    bcd_decode = 7'h78;
      4'd8:    bcd_decode = 7'h00;
      4'd9:    bcd_decode = 7'h10;
      default: bcd_decode = 7'h3F;  // lone dash flags a non-BCD code
    endcase
  endfunction

  always_comb begin
    slot_end  = (cnt == CNT_LAST);
    frame_end = slot_end && (idx == 3'd5);
    cur_dig   = snap[0];
    case (idx)
      3'd1:    cur_dig = snap[1];
      3'd2:    cur_dig = snap[2];
      3'd3:    cur_dig = snap[3];
      3'd4:    cur_dig = snap[4];
      3'd5:    cur_dig = snap[5];
      default: cur_dig = snap[0];
    endcase
    lit = !blank && (cnt >= CNT_GUARD);
`ifdef SEG7_LZB_EN
    lzb = (idx == 3'd5) && (snap[5] == 4'd0);
`else
    lzb = 1'b0;
`endif
    an_d  = lit ? ~(6'b000001 << idx) : 6'h3F;
    seg_d = lzb ? 7'h7F : bcd_decode(cur_dig);
    dp_d  = !(lit && DP_MASK8[idx] && !lzb);
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt   <= '0;
      idx   <= '0;
      for (int i = 0; i < 6; i++) snap[i] <= '0;
      an_n  <= 6'h3F;
      seg_n <= 7'h7F;
      dp_n  <= 1'b1;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // Capture all six digits together so a carry can never tear across a frame
      if (frame_end) begin
        snap[0] <= DIG0;
        snap[1] <= DIG1;
        snap[2] <= DIG2;
        snap[3] <= DIG3;
        snap[4] <= DIG4;
        snap[5] <= DIG5;
      end
      an_n  <= an_d;
      seg_n <= seg_d;
      dp_n  <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver at SCAN_DIV=8, GUARD=2: the stimulus queues the expected outputs and a monitor compares them.
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic [3:0] DIG0 = '0, DIG1 = '0, DIG2 = '0, DIG3 = '0, DIG4 = '0, DIG5 = '0;
  logic       blank = 1'b0;
  logic [5:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;

  typedef struct packed {
    logic [31:0] tag;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         mt = 0;
  logic [3:0] m_snap [6];
  logic [5:0] dp_ref = 6'b010100;

  seg7_scan_driver #(.SCAN_DIV(8), .GUARD(2), .DP_MASK(6'b010100)) dut (
    .clk(clk), .res(res),
    .DIG0(DIG0), .DIG1(DIG1), .DIG2(DIG2), .DIG3(DIG3), .DIG4(DIG4), .DIG5(DIG5),
    .blank(blank), .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_ref(input logic [3:0] d);
    case (d)
      4'd0: seg_ref = 7'h40;  4'd1: seg_ref = 7'h79;  4'd2: seg_ref = 7'h24;
      4'd3: seg_ref = 7'h30;  4'd4: seg_ref = 7'h19;  4'd5: seg_ref = 7'h12;
      4'd6: seg_ref = 7'h02;  4'd7: seg_ref = 7'h78;  4'd8: seg_ref = 7'h00;
      4'd9: seg_ref = 7'h10;  default: seg_ref = 7'h3F;
    endcase
  endfunction

  task automatic set_dig(input logic [3:0] d5, d4, d3, d2, d1, d0);
    DIG5 = d5; DIG4 = d4; DIG3 = d3; DIG2 = d2; DIG1 = d1; DIG0 = d0;
  endtask

  // Expected output after the next edge, derived from elapsed cycles since reset release
  task automatic cyc();
    int   c, sl;
    logic en, lz;
    exp_t e;
    c  = mt % 8;
    sl = (mt / 8) % 6;
    en = !blank && (c >= 2);
    lz = 1'b0;
`ifdef SEG7_LZB_EN
    lz = (sl == 5) && (m_snap[5] == 4'd0);
`endif
    e.tag = mt;
    e.an  = en ? ~(6'b000001 << sl) : 6'h3F;
    e.seg = lz ? 7'h7F : seg_ref(m_snap[sl]);
    e.dp  = (en && dp_ref[sl] && !lz) ? 1'b0 : 1'b1;
    q.push_back(e);
    if (mt % 48 == 47) begin
      m_snap[0] = DIG0; m_snap[1] = DIG1; m_snap[2] = DIG2;
      m_snap[3] = DIG3; m_snap[4] = DIG4; m_snap[5] = DIG5;
    end
    mt++;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    exp_t e;
    e.tag = 32'hFFFF_FFFF;
    e.an  = 6'h3F;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    q.push_back(e);
    res = 1'b1;
    mt  = 0;
    for (int i = 0; i < 6; i++) m_snap[i] = 4'd0;
    repeat (2) @(posedge clk);
    #2;
    res = 1'b0;
  endtask

  // Fires on a clock edge, or on res rising so the asynchronous reset is seen before any edge
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or posedge res);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (an_n !== e.an || seg_n !== e.seg || dp_n !== e.dp) begin
          errors++;
          $display("FAIL out t=%0d got an_n=%h seg_n=%h dp_n=%b want an_n=%h seg_n=%h dp_n=%b",
                   $signed(e.tag), an_n, seg_n, dp_n, e.an, e.seg, e.dp);
        end
      end
    end
  end

  initial begin : stimulus
    #1;
    set_dig(0, 0, 0, 0, 0, 0);
    do_reset();
    repeat (60) cyc();

    set_dig(1, 2, 3, 4, 5, 6);
    do_reset();
    repeat (72) cyc();
    DIG0 = 4'd9;
    repeat (44) cyc();
    DIG3 = 4'hC;
    repeat (76) cyc();
    repeat (10) cyc();
    blank = 1'b1;
    repeat (20) cyc();
    blank = 1'b0;
    while (mt % 48 != 29) cyc();

    set_dig(0, 2, 3, 4, 5, 6);
    do_reset();
    repeat (100) cyc();

    @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
